// File: rtl/mpsk_modulator.sv
// M-ary PSK modulator: serialises a latched word MSB-first into BPSK/QPSK/8-PSK
// symbols rendered from an 8-point sine table, with load handshake and done pulse.
module mpsk_modulator #(
  parameter int DATA_W      = 16,
  parameter int CYC_PER_SYM = 1,
  parameter int OUT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld,
  input  logic [DATA_W-1:0]       data,
  input  logic [1:0]              mode,
  output logic signed [OUT_W-1:0] mod_out,
  output logic                    valid,
  output logic                    busy,
  output logic                    done
);

  localparam int SW = (CYC_PER_SYM > 1) ? $clog2(CYC_PER_SYM) : 1;
  localparam int NW = $clog2(DATA_W + 1);
  localparam logic [SW-1:0] STR_LAST = SW'(CYC_PER_SYM - 1);
  localparam logic [NW-1:0] NS1M = NW'(DATA_W - 1);
  localparam logic [NW-1:0] NS2M = NW'((DATA_W + 1) / 2 - 1);
  localparam logic [NW-1:0] NS3M = NW'((DATA_W + 2) / 3 - 1);

  // LOAD is the single cycle between acceptance from IDLE and sample 0.
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              ph_q, ph_d;
  logic [SW-1:0]           str_q, str_d;
  logic [NW-1:0]           sym_q, sym_d;
  logic [DATA_W-1:0]       sh_q, sh_d;
  logic [1:0]              k_q, k_d;
  logic signed [OUT_W-1:0] out_q, out_d;
  logic [NW-1:0]           sym_last;
  logic                    last;

  function automatic logic [1:0] bits_per_sym(input logic [1:0] m);
    case (m)
      2'd1:    return 2'd2;
      2'd2:    return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  // b holds the next three data bits, MSB first; unused low bits are ignored.
  function automatic logic [2:0] sym_off(input logic [1:0] k, input logic [2:0] b);
    logic [2:0] o;
    case (k)
      2'd2: case (b[2:1])
              2'b00:   o = 3'd1;
              2'b01:   o = 3'd3;
              2'b11:   o = 3'd5;
              default: o = 3'd7;
            endcase
      2'd3: case (b)
              3'b000:  o = 3'd0;
              3'b001:  o = 3'd1;
              3'b011:  o = 3'd2;
              3'b010:  o = 3'd3;
              3'b110:  o = 3'd4;
              3'b111:  o = 3'd5;
              3'b101:  o = 3'd6;
              default: o = 3'd7;
            endcase
      default: o = b[2] ? 3'd0 : 3'd4;
    endcase
    return o;
  endfunction

  function automatic logic signed [OUT_W-1:0] carrier(input logic [2:0] idx);
    logic signed [15:0] v;
    case (idx)
      3'd0, 3'd4: v = 16'sd0;
      3'd1, 3'd3: v = 16'sd23170;
      3'd2:       v = 16'sd32767;
      3'd5, 3'd7: v = -16'sd23170;
      default:    v = -16'sd32767;
    endcase
    return OUT_W'(v >>> (16 - OUT_W));
  endfunction

  always_comb begin
    case (k_q)
      2'd2:    sym_last = NS2M;
      2'd3:    sym_last = NS3M;
      default: sym_last = NS1M;
    endcase
  end

  assign last = (state_q == RUN) && (ph_q == 3'd7) && (str_q == STR_LAST) && (sym_q == sym_last);

  // state / counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      str_q   <= '0;
      sym_q   <= '0;
      sh_q    <= '0;
      k_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      str_q   <= str_d;
      sym_q   <= sym_d;
      sh_q    <= sh_d;
      k_q     <= k_d;
      out_q   <= out_d;
    end
  end

  // next state; counters track the sample currently on mod_out
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    str_d   = str_q;
    sym_d   = sym_q;
    sh_d    = sh_q;
    k_d     = k_q;
    if ((state_q == IDLE && ld) || (last && ld)) begin
      state_d = (state_q == IDLE) ? LOAD : RUN;
      ph_d    = '0;
      str_d   = '0;
      sym_d   = '0;
      sh_d    = data;
      k_d     = bits_per_sym(mode);
    end else if (last) begin
      state_d = IDLE;
      ph_d    = '0;
      str_d   = '0;
      sym_d   = '0;
    end else if (state_q == LOAD) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      ph_d = ph_q + 3'd1;
      if (ph_q == 3'd7) begin
        if (str_q == STR_LAST) begin
          str_d = '0;
          sym_d = sym_q + 1'b1;
          sh_d  = sh_q << k_q;
        end else begin
          str_d = str_q + 1'b1;
        end
      end
    end
  end

  // output: sample selected by the next-state counters, registered with them
  always_comb begin
    out_d = '0;
    if (state_d == RUN)
      out_d = carrier(ph_d + sym_off(k_d, sh_d[DATA_W-1 -: 3]));
  end

  assign mod_out = out_q;
  assign valid   = (state_q == RUN);
  assign busy    = (state_q == RUN);
  assign done    = last;

endmodule

// File: tb/tb_mpsk_modulator.sv
// Directed bench for mpsk_modulator: three instances cover default, stretched
// symbols (CYC_PER_SYM=2) and narrow output (OUT_W=12).
module tb_mpsk_modulator;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0, tot_cnt = 0;
  int T16 [8] = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};
  int T12 [8] = '{0, 1448, 2047, 1448, 0, -1449, -2048, -1449};

  logic rst_a = 1'b1, ld_a = 1'b0; logic [15:0] data_a = '0; logic [1:0] mode_a = '0;
  logic signed [15:0] out_a; logic valid_a, busy_a, done_a;
  logic rst_b = 1'b1, ld_b = 1'b0; logic [15:0] data_b = '0; logic [1:0] mode_b = '0;
  logic signed [15:0] out_b; logic valid_b, busy_b, done_b;
  logic rst_c = 1'b1, ld_c = 1'b0; logic [15:0] data_c = '0; logic [1:0] mode_c = '0;
  logic signed [11:0] out_c; logic valid_c, busy_c, done_c;

  mpsk_modulator #(.DATA_W(16), .CYC_PER_SYM(1), .OUT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .ld(ld_a), .data(data_a), .mode(mode_a),
    .mod_out(out_a), .valid(valid_a), .busy(busy_a), .done(done_a));
  mpsk_modulator #(.DATA_W(16), .CYC_PER_SYM(2), .OUT_W(16)) dut_b (
    .clk(clk), .rst(rst_b), .ld(ld_b), .data(data_b), .mode(mode_b),
    .mod_out(out_b), .valid(valid_b), .busy(busy_b), .done(done_b));
  mpsk_modulator #(.DATA_W(16), .CYC_PER_SYM(1), .OUT_W(12)) dut_c (
    .clk(clk), .rst(rst_c), .ld(ld_c), .data(data_c), .mode(mode_c),
    .mod_out(out_c), .valid(valid_c), .busy(busy_c), .done(done_c));

  task automatic start_a(input logic [15:0] d, input logic [1:0] m);
    @(negedge clk); ld_a = 1'b1; data_a = d; mode_a = m;
    @(negedge clk); ld_a = 1'b0; data_a = ~d; mode_a = 2'd2;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; ld_a = 1'b1; data_a = 16'hAAAA; mode_a = 2'd0;
    repeat (3) @(negedge clk);
    tot_cnt++; if (out_a !== 16'sd0) $display("FAIL reset_out act=%0d req=0", out_a); else pass_cnt++;
    tot_cnt++; if ({valid_a, busy_a, done_a} !== 3'b000) $display("FAIL reset_flags act=%b req=000", {valid_a, busy_a, done_a}); else pass_cnt++;
    ld_a = 1'b0; rst_a = 1'b0;
    repeat (4) @(negedge clk);
    tot_cnt++; if ({valid_a, busy_a, done_a} !== 3'b000 || out_a !== 16'sd0)
      $display("FAIL idle_after_release act=%b/%0d req=000/0", {valid_a, busy_a, done_a}, out_a); else pass_cnt++;
  endtask

  task automatic test_bpsk();
    logic [15:0] d = 16'hAAAA;
    int b, e;
    start_a(d, 2'd0);
    tot_cnt++; if (valid_a !== 1'b0) $display("FAIL bpsk_latency valid act=%b req=0", valid_a); else pass_cnt++;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      b = d[15 - i/8];
      e = T16[(i%8 + (b ? 0 : 4)) % 8];
      tot_cnt++; if (out_a !== 16'(e)) $display("FAIL bpsk_sample[%0d] act=%0d req=%0d", i, out_a, e); else pass_cnt++;
      tot_cnt++; if ({valid_a, busy_a} !== 2'b11) $display("FAIL bpsk_valid[%0d] act=%b req=11", i, {valid_a, busy_a}); else pass_cnt++;
      tot_cnt++; if (done_a !== (i == 127)) $display("FAIL bpsk_done[%0d] act=%b req=%b", i, done_a, i == 127); else pass_cnt++;
    end
    @(negedge clk);
    tot_cnt++; if ({valid_a, busy_a, done_a} !== 3'b000 || out_a !== 16'sd0)
      $display("FAIL bpsk_end act=%b/%0d req=000/0", {valid_a, busy_a, done_a}, out_a); else pass_cnt++;
  endtask

  task automatic test_qpsk();
    int q0 [9] = '{23170, 32767, 23170, 0, -23170, -32767, -23170, 0, 23170};
    start_a(16'h1E1E, 2'd1);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i < 9) begin
        tot_cnt++; if (out_a !== 16'(q0[i])) $display("FAIL qpsk_sample[%0d] act=%0d req=%0d", i, out_a, q0[i]); else pass_cnt++;
      end
      if (i == 63) begin
        tot_cnt++; if (out_a !== -16'sd32767) $display("FAIL qpsk_last act=%0d req=-32767", out_a); else pass_cnt++;
      end
      tot_cnt++; if (valid_a !== 1'b1) $display("FAIL qpsk_valid[%0d] act=%b req=1", i, valid_a); else pass_cnt++;
      tot_cnt++; if (done_a !== (i == 63)) $display("FAIL qpsk_done[%0d] act=%b req=%b", i, done_a, i == 63); else pass_cnt++;
    end
    @(negedge clk);
    tot_cnt++; if (valid_a !== 1'b0) $display("FAIL qpsk_end valid act=%b req=0", valid_a); else pass_cnt++;
  endtask

  task automatic test_8psk();
    int off, e;
    start_a(16'hFFFF, 2'd2);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      off = (i < 40) ? 5 : 7;
      e = T16[(i%8 + off) % 8];
      tot_cnt++; if (out_a !== 16'(e)) $display("FAIL psk8_sample[%0d] act=%0d req=%0d", i, out_a, e); else pass_cnt++;
      tot_cnt++; if (done_a !== (i == 47)) $display("FAIL psk8_done[%0d] act=%b req=%b", i, done_a, i == 47); else pass_cnt++;
    end
    @(negedge clk);
    tot_cnt++; if (valid_a !== 1'b0) $display("FAIL psk8_end valid act=%b req=0", valid_a); else pass_cnt++;
  endtask

  // ld held high, reserved mode 3 behaves as BPSK; two contiguous frames
  task automatic test_back_to_back();
    logic [15:0] d = 16'hAAAA;
    int j, b, e;
    @(negedge clk); ld_a = 1'b1; data_a = d; mode_a = 2'd3;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      j = i % 128;
      b = d[15 - j/8];
      e = T16[(j%8 + (b ? 0 : 4)) % 8];
      tot_cnt++; if (out_a !== 16'(e)) $display("FAIL b2b_sample[%0d] act=%0d req=%0d", i, out_a, e); else pass_cnt++;
      tot_cnt++; if (valid_a !== 1'b1) $display("FAIL b2b_valid[%0d] act=%b req=1", i, valid_a); else pass_cnt++;
      tot_cnt++; if (done_a !== (j == 127)) $display("FAIL b2b_done[%0d] act=%b req=%b", i, done_a, j == 127); else pass_cnt++;
      if (i == 255) ld_a = 1'b0;
    end
    @(negedge clk);
    tot_cnt++; if (valid_a !== 1'b0) $display("FAIL b2b_end valid act=%b req=0", valid_a); else pass_cnt++;
  endtask

  task automatic test_stretch();
    logic [15:0] d0 = 16'hAAAA, d1 = 16'h5555, d;
    int b, e;
    @(negedge clk); ld_b = 1'b1; data_b = d0; mode_b = 2'd0;
    @(negedge clk); ld_b = 1'b0;
    for (int f = 0; f < 2; f++) begin
      d = (f == 0) ? d0 : d1;
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        b = d[15 - i/16];
        e = T16[(i%8 + (b ? 0 : 4)) % 8];
        tot_cnt++; if (out_b !== 16'(e)) $display("FAIL stretch_sample[%0d][%0d] act=%0d req=%0d", f, i, out_b, e); else pass_cnt++;
        tot_cnt++; if (valid_b !== 1'b1) $display("FAIL stretch_valid[%0d][%0d] act=%b req=1", f, i, valid_b); else pass_cnt++;
        tot_cnt++; if (done_b !== (i == 255)) $display("FAIL stretch_done[%0d][%0d] act=%b req=%b", f, i, done_b, i == 255); else pass_cnt++;
        if (f == 0 && i == 50)  begin ld_b = 1'b1; data_b = 16'h0000; mode_b = 2'd2; end
        if (f == 0 && i == 51)  ld_b = 1'b0;
        if (f == 0 && i == 255) begin ld_b = 1'b1; data_b = d1; mode_b = 2'd0; end
        if (f == 1 && i == 0)   ld_b = 1'b0;
      end
    end
    @(negedge clk);
    tot_cnt++; if (valid_b !== 1'b0) $display("FAIL stretch_end valid act=%b req=0", valid_b); else pass_cnt++;
  endtask

  task automatic test_outw12();
    logic [15:0] d = 16'hAAAA;
    int b, e;
    @(negedge clk); ld_c = 1'b1; data_c = d; mode_c = 2'd0;
    @(negedge clk); ld_c = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      b = d[15 - i/8];
      e = T12[(i%8 + (b ? 0 : 4)) % 8];
      tot_cnt++; if (out_c !== 12'(e)) $display("FAIL w12_sample[%0d] act=%0d req=%0d", i, out_c, e); else pass_cnt++;
    end
    rst_c = 1'b1;
    #1;
    tot_cnt++; if ({valid_c, busy_c, done_c} !== 3'b000 || out_c !== 12'sd0)
      $display("FAIL w12_async_reset act=%b/%0d req=000/0", {valid_c, busy_c, done_c}, out_c); else pass_cnt++;
    @(negedge clk); rst_c = 1'b0;
    repeat (3) @(negedge clk);
    tot_cnt++; if (valid_c !== 1'b0) $display("FAIL w12_idle_after_reset act=%b req=0", valid_c); else pass_cnt++;
    @(negedge clk); ld_c = 1'b1;
    @(negedge clk); ld_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tot_cnt++; if (out_c !== 12'(T12[i]) || valid_c !== 1'b1)
        $display("FAIL w12_restart[%0d] act=%0d/%b req=%0d/1", i, out_c, valid_c, T12[i]); else pass_cnt++;
    end
    repeat (125) @(negedge clk);
    tot_cnt++; if (valid_c !== 1'b0) $display("FAIL w12_end valid act=%b req=0", valid_c); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    rst_b = 1'b0;
    rst_c = 1'b0;
    test_bpsk();
    test_qpsk();
    test_8psk();
    test_back_to_back();
    test_stretch();
    test_outw12();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/mpsk_modulator.md
# mpsk_modulator

Parametrised M-ary PSK modulator, the next generation of our 16-bit BPSK modulator. It loads a parallel data word and serialises it MSB-first into BPSK, QPSK or 8-PSK symbols, with the mode selected per frame. Each symbol is rendered as signed carrier samples from a fixed 8-point sine table, with phase offsets in multiples of 45°. It sits between the framing logic and the DAC interface, and adds a load handshake, back-to-back frames, symbol stretching and a frame-done pulse.

## Interface
- DATA_W, 16, bits per loaded word (>= 3)
- CYC_PER_SYM, 1, carrier cycles per symbol (>= 1); a symbol lasts 8*CYC_PER_SYM samples
- OUT_W, 16, output sample width (8..16)
- clk  in  1  sample clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ld  in  1  load strobe; accepted per the handshake rules
- data  in  DATA_W  word to transmit, MSB sent first
- mode  in  2  0 = BPSK, 1 = QPSK, 2 = 8-PSK, 3 = reserved (treated as BPSK)
- mod_out  out  OUT_W  signed modulated sample, registered
- valid  out  1  mod_out carries a frame sample
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse on the last sample of a frame

## Operation
- Carrier table: T[0..7] = 0, 23170, 32767, 23170, 0, -23170, -32767, -23170 (16-bit signed). For OUT_W < 16, each entry is arithmetically right-shifted by 16-OUT_W.
- Bits per symbol: k = 1, 2 or 3 according to mode.
- Symbols per frame: NS = ceil(DATA_W/k). Missing trailing LSBs of the last symbol are padded with 0.
- Phase offset per symbol:
  - BPSK: 1 -> 0, 0 -> 4.
  - QPSK (Gray): 00 -> 1, 01 -> 3, 11 -> 5, 10 -> 7.
  - 8-PSK (Gray): 000 -> 0, 001 -> 1, 011 -> 2, 010 -> 3, 110 -> 4, 111 -> 5, 101 -> 6, 100 -> 7.
- Sample i of the frame (i = 0..NS*8*CYC_PER_SYM-1) is T[(i mod 8 + off(sym)) mod 8], where sym = i / (8*CYC_PER_SYM). The carrier phase is continuous across symbol boundaries within a frame.
- States:
  - IDLE: busy=0, valid=0, mod_out=0.
  - RUN: busy=1, valid=1.
  - IDLE -> RUN when ld=1.
  - RUN -> IDLE after the last sample, unless ld=1 on that cycle.
- data and mode are latched on acceptance. Changes to them during RUN have no effect.
- Handshake:
  - ld is accepted in IDLE, or in RUN on the cycle of the final sample (done=1).
  - ld at any other RUN cycle is ignored; no queueing.
  - Back-to-back acceptance starts the new frame at i=0 with no gap cycle.
- Counters: a 3-bit sample phase, a symbol-stretch counter to CYC_PER_SYM, and a symbol counter to NS. All wrap cleanly; no sample is dropped or repeated.

## Timing
- Latency: ld accepted at edge t -> sample 0 is on mod_out after edge t+1. The last sample is after edge t+NS*8*CYC_PER_SYM.
- valid and busy rise with sample 0 and fall the cycle after the last sample, unless a new frame was loaded.
- done is high exactly during the last sample cycle.
- Reset values: mod_out=0, valid=0, busy=0, done=0, state IDLE, all counters 0.
- Reset mid-frame aborts the frame immediately (asynchronously). The first ld after reset release starts a fresh frame.
- ld held high continuously: one frame per acceptance point, i.e. contiguous frames.

## Test plan
- Reset: assert rst with ld=1 -> all outputs 0. After release, nothing happens until ld is sampled high.
- BPSK, DATA_W=16, CYC_PER_SYM=1, data=16'hAAAA:
  - mod_out = 0, 23170, 32767, 23170, 0, -23170, -32767, -23170, then the negated sequence, alternating.
  - 128 valid cycles; done on cycle 128 only.
- QPSK, data=16'b00_01_11_10_00_01_11_10:
  - Symbol 0 samples = T[1..7], T[0] = 23170, 32767, 23170, 0, -23170, -32767, -23170, 0.
  - Symbol 1 starts at T[3] = 23170.
  - 64 valid cycles.
- 8-PSK, DATA_W=16, data=16'hFFFF:
  - 6 symbols (48 samples): first five use offset 5; the sixth (1,0,0 padded) uses offset 7.
- CYC_PER_SYM=2, BPSK:
  - Each symbol spans 16 samples with phase continuous.
  - ld pulse mid-frame ignored.
  - ld on the done cycle starts the next frame with valid held high, no gap.
- OUT_W=12:
  - Peak 2047, trough -2048, T[1] = 1448.
  - rst asserted at sample 20 -> outputs 0 immediately.
